// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two requesters (m0 = CPU, m1 = DMA), the arbiter and the io register file.
interface io_bus_arbiter_if;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_write;
    logic [1:0]        m0_width;
    logic              m0_lock;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_write;
    logic [1:0]        m1_width;
    logic              m1_lock;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_data_in;
    logic              io_read;
    logic              io_write;
    logic [1:0]        io_width;
    logic [DATA_W-1:0] io_data_out;

    // Arbiter side
    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_write, m0_width, m0_lock,
        output m0_ack, m0_rdata,
        input  m1_req, m1_addr, m1_wdata, m1_write, m1_width, m1_lock,
        output m1_ack, m1_rdata,
        output io_addr, io_data_in, io_read, io_write, io_width,
        input  io_data_out
    );

    // Requester / register-file side
    modport master (
        output m0_req, m0_addr, m0_wdata, m0_write, m0_width, m0_lock,
        input  m0_ack, m0_rdata,
        output m1_req, m1_addr, m1_wdata, m1_write, m1_width, m1_lock,
        input  m1_ack, m1_rdata,
        input  io_addr, io_data_in, io_read, io_write, io_width,
        output io_data_out
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter in front of an io register file: IDLE -> ISSUE -> RESP with optional lock.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module io_bus_arbiter (
    input  logic            clk_mem,
    input  logic            rst_n,
    io_bus_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              write;
        logic [1:0]        width;
        logic              lock;
    } req_t;

    state_t state;
    logic   gnt;
    logic   lock;
`ifdef IO_ARB_ROUND_ROBIN_EN
    logic   rr_ptr;
`endif

    logic win_c;
    logic sel_c;
    logic sel_req_c;
    logic load_c;
    req_t sel_fields_c;

    // Winner selection, and the field mux shared by arbitration and locked re-issue
    always_comb begin
        win_c = 1'b0;
`ifdef IO_ARB_ROUND_ROBIN_EN
        if (bus.m0_req && bus.m1_req) win_c = rr_ptr;
        else                          win_c = ~bus.m0_req;
`else
        win_c = ~bus.m0_req;
`endif
        sel_c     = (state == RESP) ? gnt : win_c;
        sel_req_c = sel_c ? bus.m1_req : bus.m0_req;
        if (sel_c) sel_fields_c = '{bus.m1_addr, bus.m1_wdata, bus.m1_write, bus.m1_width, bus.m1_lock};
        else       sel_fields_c = '{bus.m0_addr, bus.m0_wdata, bus.m0_write, bus.m0_width, bus.m0_lock};
        load_c = ((state == IDLE) && (bus.m0_req || bus.m1_req)) ||
                 ((state == RESP) && lock && sel_req_c);
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            lock           <= 1'b0;
`ifdef IO_ARB_ROUND_ROBIN_EN
            rr_ptr         <= 1'b0;
`endif
            bus.m0_ack     <= 1'b0;
            bus.m1_ack     <= 1'b0;
            bus.m0_rdata   <= '0;
            bus.m1_rdata   <= '0;
            bus.io_addr    <= '0;
            bus.io_data_in <= '0;
            bus.io_width   <= 2'b00;
            bus.io_read    <= 1'b0;
            bus.io_write   <= 1'b0;
        end else begin
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.io_read  <= 1'b0;
            bus.io_write <= 1'b0;

            // Fields go straight into the io registers so the strobe lines up with ISSUE
            if (load_c) begin
                gnt            <= sel_c;
                lock           <= sel_fields_c.lock;
                bus.io_addr    <= sel_fields_c.addr;
                bus.io_data_in <= sel_fields_c.wdata;
                bus.io_width   <= sel_fields_c.width;
                bus.io_read    <= ~sel_fields_c.write;
                bus.io_write   <= sel_fields_c.write;
            end

            case (state)
                IDLE: begin
                    if (load_c) begin
                        state <= ISSUE;
`ifdef IO_ARB_ROUND_ROBIN_EN
                        rr_ptr <= ~win_c;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.io_read) begin
                        if (gnt) bus.m1_rdata <= bus.io_data_out;
                        else     bus.m0_rdata <= bus.io_data_out;
                    end
                    if (gnt) bus.m1_ack <= 1'b1;
                    else     bus.m0_ack <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    state <= load_c ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter; expectations follow the build's IO_ARB_ROUND_ROBIN_EN setting.
module tb_io_bus_arbiter;
    logic clk_mem = 1'b0;
    logic rst_n;

    io_bus_arbiter_if bus ();

    io_bus_arbiter dut (
        .clk_mem (clk_mem),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk_mem = ~clk_mem;

    // Register-file model: one known location, everything else echoes its address
    assign bus.io_data_out = (bus.io_addr == 24'h000130) ? 32'h0000_03FF : {8'hA5, bus.io_addr};

    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    logic [23:0] wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic [1:0]  wr_width = '0;

    always @(posedge clk_mem) begin
        if (bus.io_read) rd_cnt <= rd_cnt + 1;
        if (bus.io_write) begin
            wr_cnt   <= wr_cnt + 1;
            wr_addr  <= bus.io_addr;
            wr_data  <= bus.io_data_in;
            wr_width <= bus.io_width;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_m0(input logic req, input logic [23:0] addr, input logic [31:0] wdata,
                            input logic write, input logic [1:0] width, input logic lock);
        bus.m0_req = req; bus.m0_addr = addr; bus.m0_wdata = wdata;
        bus.m0_write = write; bus.m0_width = width; bus.m0_lock = lock;
    endtask

    task automatic drive_m1(input logic req, input logic [23:0] addr, input logic [31:0] wdata,
                            input logic write, input logic [1:0] width, input logic lock);
        bus.m1_req = req; bus.m1_addr = addr; bus.m1_wdata = wdata;
        bus.m1_write = write; bus.m1_width = width; bus.m1_lock = lock;
    endtask

    initial begin
        int n_ack;
        int ack_at [4];
        logic ack_who [4];
        int m1_n, a1, a2, a3, m0_seen, rd0;
        logic exp_who;

        rst_n = 1'b0;
        drive_m0(1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        drive_m1(1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        repeat (2) @(negedge clk_mem);

        check("rst_m0_ack",   32'(bus.m0_ack),   32'd0);
        check("rst_m1_ack",   32'(bus.m1_ack),   32'd0);
        check("rst_io_read",  32'(bus.io_read),  32'd0);
        check("rst_io_write", 32'(bus.io_write), 32'd0);
        check("rst_io_addr",  32'(bus.io_addr),  32'd0);
        check("rst_m0_rdata", bus.m0_rdata,      32'd0);
        check("rst_m1_rdata", bus.m1_rdata,      32'd0);

        // Single read by m0, requested on the first edge after reset release
        rst_n = 1'b1;
        drive_m0(1'b1, 24'h000130, 32'h0, 1'b0, 2'b10, 1'b0);
        @(posedge clk_mem); #1;
        check("rd_io_read",  32'(bus.io_read),  32'd1);
        check("rd_io_write", 32'(bus.io_write), 32'd0);
        check("rd_io_addr",  32'(bus.io_addr),  32'h130);
        check("rd_io_width", 32'(bus.io_width), 32'd2);
        check("rd_no_early_ack", 32'(bus.m0_ack), 32'd0);
        @(posedge clk_mem); #1;
        check("rd_strobe_end", 32'(bus.io_read), 32'd0);
        check("rd_m0_ack",     32'(bus.m0_ack),  32'd1);
        check("rd_m1_ack",     32'(bus.m1_ack),  32'd0);
        check("rd_m0_rdata",   bus.m0_rdata,     32'h0000_03FF);
        bus.m0_req = 1'b0;
        @(posedge clk_mem); #1;
        check("rd_ack_pulse", 32'(bus.m0_ack), 32'd0);
        check("rd_count",     32'(rd_cnt),     32'd1);

        // Single write by m1
        drive_m1(1'b1, 24'h000404, 32'h0000_0007, 1'b1, 2'b00, 1'b0);
        @(posedge clk_mem); #1;
        check("wr_io_write", 32'(bus.io_write),  32'd1);
        check("wr_io_read",  32'(bus.io_read),   32'd0);
        check("wr_io_addr",  32'(bus.io_addr),   32'h404);
        check("wr_io_data",  bus.io_data_in,     32'h7);
        check("wr_io_width", 32'(bus.io_width),  32'd0);
        @(posedge clk_mem); #1;
        check("wr_m1_ack",   32'(bus.m1_ack),    32'd1);
        check("wr_m0_ack",   32'(bus.m0_ack),    32'd0);
        check("wr_m1_rdata", bus.m1_rdata,       32'd0);
        bus.m1_req = 1'b0;
        @(posedge clk_mem); #1;
        check("wr_count",    32'(wr_cnt),        32'd1);
        check("wr_addr_seen",32'(wr_addr),       32'h404);
        check("wr_data_seen",wr_data,            32'h7);
        check("wr_rd_count", 32'(rd_cnt),        32'd1);
        check("wr_m0_rdata_kept", bus.m0_rdata,  32'h0000_03FF);

        // Contention: both request continuously for four transactions
        @(negedge clk_mem);
        drive_m0(1'b1, 24'h000010, 32'h0, 1'b0, 2'b10, 1'b0);
        drive_m1(1'b1, 24'h000020, 32'h0, 1'b0, 2'b10, 1'b0);
        n_ack = 0;
        for (int k = 0; k < 4; k++) begin ack_at[k] = 0; ack_who[k] = 1'b0; end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_mem);
            if (bus.m0_ack && bus.m1_ack) check("ct_dual_ack", 32'd1, 32'd0);
            if (bus.m0_ack || bus.m1_ack) begin
                ack_at[n_ack]  = i;
                ack_who[n_ack] = bus.m1_ack;
                n_ack++;
                if (n_ack == 4) begin
                    bus.m0_req = 1'b0;
                    bus.m1_req = 1'b0;
                    break;
                end
            end
        end
        check("ct_ack_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef IO_ARB_ROUND_ROBIN_EN
            exp_who = (k % 2 == 1);
`else
            exp_who = 1'b0;
`endif
            check($sformatf("ct_ack%0d_cycle", k), 32'(ack_at[k]), 32'(2 + 3 * k));
            check($sformatf("ct_ack%0d_who", k),   32'(ack_who[k]), 32'(exp_who));
        end
        check("ct_m0_rdata", bus.m0_rdata, 32'hA500_0010);
`ifdef IO_ARB_ROUND_ROBIN_EN
        check("ct_m1_rdata", bus.m1_rdata, 32'hA500_0020);
`else
        check("ct_m1_rdata", bus.m1_rdata, 32'd0);
`endif
        repeat (2) @(negedge clk_mem);

        // Lock: m1 read then write back-to-back while m0 waits
        drive_m1(1'b1, 24'h000100, 32'h0, 1'b0, 2'b10, 1'b1);
        m1_n = 0; a1 = 0; a2 = 0; a3 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_mem);
            if (i == 1) drive_m0(1'b1, 24'h000010, 32'h0, 1'b0, 2'b10, 1'b0);
            if (bus.m1_ack) begin
                m1_n++;
                if (m1_n == 1) begin
                    a1 = i;
                    drive_m1(1'b1, 24'h000100, 32'h0000_0055, 1'b1, 2'b10, 1'b0);
                end else begin
                    a2 = i;
                    bus.m1_req = 1'b0;
                end
            end
            if (bus.m0_ack) begin
                a3 = i;
                bus.m0_req = 1'b0;
                break;
            end
        end
        check("lk_m1_ack1_cycle", 32'(a1), 32'd2);
        check("lk_m1_ack2_cycle", 32'(a2), 32'd4);
        check("lk_m0_ack_cycle",  32'(a3), 32'd7);
        check("lk_m1_rdata",      bus.m1_rdata, 32'hA500_0100);
        check("lk_wr_count",      32'(wr_cnt),  32'd2);
        check("lk_wr_addr",       32'(wr_addr), 32'h100);
        check("lk_wr_data",       wr_data,      32'h55);
        repeat (2) @(negedge clk_mem);

        // A req that drops before it is granted is ignored
        rd0 = rd_cnt;
        m0_seen = 0;
        drive_m1(1'b1, 24'h000020, 32'h0, 1'b0, 2'b10, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_mem);
            if (bus.m0_ack) m0_seen++;
            if (i == 1) drive_m0(1'b1, 24'h000030, 32'h0, 1'b0, 2'b10, 1'b0);
            if (i == 2) bus.m0_req = 1'b0;
            if (bus.m1_ack) bus.m1_req = 1'b0;
        end
        check("dr_m0_no_ack",   32'(m0_seen), 32'd0);
        check("dr_read_count",  32'(rd_cnt),  32'(rd0 + 1));
        check("dr_m1_rdata",    bus.m1_rdata, 32'hA500_0020);

        // Reset in the middle of an m0 read
        drive_m0(1'b1, 24'h000130, 32'h0, 1'b0, 2'b10, 1'b0);
        @(posedge clk_mem); #1;
        check("mr_pre_io_read", 32'(bus.io_read), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_io_read",  32'(bus.io_read),  32'd0);
        check("mr_io_addr",  32'(bus.io_addr),  32'd0);
        check("mr_io_data",  bus.io_data_in,    32'd0);
        check("mr_io_width", 32'(bus.io_width), 32'd0);
        check("mr_m0_rdata", bus.m0_rdata,      32'd0);
        check("mr_m1_rdata", bus.m1_rdata,      32'd0);
        check("mr_m0_ack",   32'(bus.m0_ack),   32'd0);
        bus.m0_req = 1'b0;
        repeat (2) @(negedge clk_mem);
        check("mr_held_ack", 32'(bus.m0_ack | bus.m1_ack), 32'd0);
        rst_n = 1'b1;
        drive_m0(1'b1, 24'h000130, 32'h0, 1'b0, 2'b10, 1'b0);
        @(posedge clk_mem); #1;
        check("mr_again_io_read", 32'(bus.io_read), 32'd1);
        @(posedge clk_mem); #1;
        check("mr_again_ack",   32'(bus.m0_ack), 32'd1);
        check("mr_again_rdata", bus.m0_rdata,    32'h0000_03FF);
        bus.m0_req = 1'b0;
        repeat (2) @(negedge clk_mem);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have ports: clk_mem  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have, per requester k in {0 = CPU, 1 = DMA}: mk_req  in  1  transaction request.
REQ-004 SHALL have: mk_addr  in  24;  mk_wdata  in  32;  mk_write  in  1 (1 = write, 0 = read);  mk_width  in  2 (00 byte, 01 half, else word).
REQ-005 SHALL have: mk_lock  in  1  keep the grant for the next transaction.
REQ-006 SHALL have: mk_ack  out  1  one-cycle completion pulse;  mk_rdata  out  32  read result, valid with ack.
REQ-007 SHALL have toward the io register file: io_addr  out  24;  io_data_in  out  32;  io_read  out  1;  io_write  out  1;  io_width  out  2;  io_data_out  in  32 (combinational read data).

Function
REQ-008 SHALL run an FSM with states IDLE, ISSUE and RESP.
REQ-009 IDLE: when any req is high, SHALL choose a winner, register its addr/wdata/write/width/lock and the grant index, and go to ISSUE.
REQ-010 ISSUE: SHALL drive io_* from the registered fields, with exactly one of io_read or io_write high for exactly one cycle; SHALL capture io_data_out into the winner's rdata at the end of the cycle; SHALL go to RESP.
REQ-011 RESP: SHALL pulse the winner's mk_ack for one cycle, with mk_rdata valid in the same cycle; the other requester's ack SHALL stay 0.
REQ-012 From RESP with the registered lock = 1 and the same requester's req = 1: SHALL register that requester's new fields and go directly to ISSUE, without arbitration.
REQ-013 From RESP otherwise: SHALL go to IDLE.
REQ-014 Latency: req sampled in IDLE at edge N -> io strobe during cycle N+1 -> ack during cycle N+2; back-to-back transactions SHALL complete every 3 cycles.
REQ-015 Locked back-to-back transactions SHALL complete every 2 cycles.
REQ-016 Requesters SHALL hold req and their fields stable until ack. A req still high on the cycle after ack SHALL be treated as a new transaction.
REQ-017 A req that drops before it is granted SHALL be ignored, with no io strobe.
REQ-018 io_read and io_write SHALL be 0 outside ISSUE; io_addr, io_data_in and io_width SHALL hold their last values.
REQ-019 mk_rdata SHALL hold its value until the next read completes for that requester. A write SHALL leave rdata unchanged.

Reset
REQ-020 Reset SHALL act immediately regardless of the clock.
REQ-021 Reset SHALL set state to IDLE, all acks/io_read/io_write to 0, io_addr/io_data_in/io_width and both rdata to 0, lock to 0 and the round-robin pointer to "m0 next".
REQ-022 Reset during ISSUE or RESP SHALL abort the transaction: no ack; a write strobe already sampled stays applied.
REQ-023 After rst_n rises, SHALL arbitrate from IDLE on the first clock edge.

Configuration
REQ-024 Macro IO_ARB_ROUND_ROBIN_EN defined: on simultaneous requests SHALL grant the requester that did not win the previous grant, and the pointer SHALL update on every grant from IDLE.
REQ-025 Macro IO_ARB_ROUND_ROBIN_EN undefined: SHALL use fixed priority with m0 (CPU) always winning ties, and no pointer register.
REQ-026 A single requester SHALL always be granted, in either configuration.

Verification
REQ-027 Single read: m0 read, addr 0x000130, width 10, io_data_out = 0x0000_03FF -> io_read high 1 cycle at addr 0x130; m0_ack 2 cycles after the req edge; m0_rdata = 0x0000_03FF.
REQ-028 Single write: m1 write, addr 0x000404, wdata 0x0000_0007, width 00 -> exactly one io_write cycle with those values; m1_ack once; m1_rdata unchanged.
REQ-029 Contention, RR build: m0 and m1 both request continuously for 4 transactions -> grant order m0, m1, m0, m1; acks every 3 cycles. Fixed build: m0 × 4, and m1 is not granted.
REQ-030 Lock: m1 lock = 1 with a read then a write to 0x000100 while m0 is requesting -> m1 gets both transactions back-to-back (acks 2 cycles apart) before m0 is granted.
REQ-031 Reset mid-op: assert rst_n = 0 during ISSUE of an m0 read -> acks stay 0, outputs reach their reset values without a clock edge, and the next request completes normally.
